traffic_phase_scheduler: RTL and testbench

Demand-actuated phase scheduler for the two-road crossroad. Latches car-sensor and pedestrian requests, shares the intersection between road A, road B and a pedestrian walk phase in round-robin order, and gives emergency preemption priority. Drives the A/B light triplets and the 4-bit countdown display directly, replacing fixed-cycle sequencing with request-driven phase selection.

---
 rtl/traffic_pkg.sv | 75 +++++++
 rtl/phase_timer.sv | 30 +++
 rtl/traffic_phase_scheduler.sv | 153 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the crossroad phase scheduler: lamp encodings, the
// phase-state enum, the round-robin grant pointer and two small helpers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_A_GREEN,
        ST_A_YELLOW,
        ST_B_GREEN,
        ST_B_YELLOW,
        ST_PED_WALK
    } phase_t;

    // Who was granted last; the round-robin search starts just after it.
    typedef enum logic [1:0] {
        GRANT_A,
        GRANT_B,
        GRANT_PED
    } grant_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       walk;
    } lamp_t;

    // Lamp pattern shown while a given phase is active.
    function automatic lamp_t decode_lamps(phase_t p);
        lamp_t l;
        l.a    = LIGHT_RED;
        l.b    = LIGHT_RED;
        l.walk = 1'b0;
        case (p)
            ST_A_GREEN:  l.a    = LIGHT_GREEN;
            ST_A_YELLOW: l.a    = LIGHT_YELLOW;
            ST_B_GREEN:  l.b    = LIGHT_GREEN;
            ST_B_YELLOW: l.b    = LIGHT_YELLOW;
            ST_PED_WALK: l.walk = 1'b1;
            default:     l.walk = 1'b0;
        endcase
        return l;
    endfunction

    // First pending requester after the last grant in A -> B -> PED order;
    // with nothing pending the intersection defaults to road A.
    function automatic phase_t rr_select(grant_t last, logic pa, logic pb, logic pp);
        phase_t sel;
        sel = ST_A_GREEN;
        case (last)
            GRANT_A: begin
                if (pb)      sel = ST_B_GREEN;
                else if (pp) sel = ST_PED_WALK;
                else         sel = ST_A_GREEN;
            end
            GRANT_B: begin
                if (pp)      sel = ST_PED_WALK;
                else if (pa) sel = ST_A_GREEN;
                else if (pb) sel = ST_B_GREEN;
                else         sel = ST_A_GREEN;
            end
            default: begin
                if (pa)      sel = ST_A_GREEN;
                else if (pb) sel = ST_B_GREEN;
                else if (pp) sel = ST_PED_WALK;
                else         sel = ST_A_GREEN;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 4-bit loadable down-counter that parks at zero; drives the countdown
// display and tells the scheduler when the current phase has expired.
module phase_timer #(
    parameter logic [3:0] RESET_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_count,
    output logic       o_zero
);

    logic [3:0] r_count;

    // Load on phase entry or emergency hold, otherwise count down and stop at 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst)
            r_count <= RESET_VAL;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != 4'd0)
            r_count <= r_count - 4'd1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 4'd0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler: latches road/pedestrian requests, grants
// A, B and the walk phase round-robin, and lets emergency vehicles preempt.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 6
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_ped,
    input  logic [1:0] emerg,
    output logic [2:0] A_lights,
    output logic [2:0] B_lights,
    output logic       ped_walk,
    output logic [3:0] num_out
);

    localparam logic [3:0] GREEN_M1  = 4'(GREEN_T - 1);
    localparam logic [3:0] YELLOW_M1 = 4'(YELLOW_T - 1);
    localparam logic [3:0] ALLRED_M1 = 4'(ALLRED_T - 1);
    localparam logic [3:0] WALK_M1   = 4'(WALK_T - 1);

    phase_t     r_state;
    grant_t     r_last;
    lamp_t      r_lamps;
    logic       r_pend_a;
    logic       r_pend_b;
    logic       r_pend_ped;

    phase_t     w_next_state;
    logic       w_load;
    logic [3:0] w_load_val;
    logic [3:0] w_count;
    logic       w_zero;
    logic       w_emerg_a;
    logic       w_emerg_b;
    logic       w_enter_a;
    logic       w_enter_b;
    logic       w_enter_ped;

    // Countdown value shown on the first cycle of each phase.
    function automatic logic [3:0] phase_len_m1(phase_t p);
        case (p)
            ST_A_GREEN, ST_B_GREEN:   return GREEN_M1;
            ST_A_YELLOW, ST_B_YELLOW: return YELLOW_M1;
            ST_PED_WALK:              return WALK_M1;
            default:                  return ALLRED_M1;
        endcase
    endfunction

    // Road A wins when both emergency bits are raised.
    assign w_emerg_a = emerg[0];
    assign w_emerg_b = emerg[1] & ~emerg[0];

    phase_timer #(
        .RESET_VAL (ALLRED_M1)
    ) u_timer (
        .clk        (clk),
        .rst        (rst_a),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // Next-phase selection and timer reload decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 4'd0;
        case (r_state)
            ST_ALL_RED: begin
                if (w_zero) begin
                    if (w_emerg_a)      w_next_state = ST_A_GREEN;
                    else if (w_emerg_b) w_next_state = ST_B_GREEN;
                    else                w_next_state = rr_select(r_last, r_pend_a, r_pend_b, r_pend_ped);
                end
            end
            ST_A_GREEN: begin
                if (w_emerg_a) begin
                    w_load     = 1'b1;
                    w_load_val = GREEN_M1;
                end else if (w_emerg_b || (w_zero && (r_pend_b || r_pend_ped))) begin
                    w_next_state = ST_A_YELLOW;
                end
            end
            ST_B_GREEN: begin
                if (w_emerg_b) begin
                    w_load     = 1'b1;
                    w_load_val = GREEN_M1;
                end else if (w_emerg_a || (w_zero && (r_pend_a || r_pend_ped))) begin
                    w_next_state = ST_B_YELLOW;
                end
            end
            ST_A_YELLOW, ST_B_YELLOW: begin
                if (w_zero) w_next_state = ST_ALL_RED;
            end
            ST_PED_WALK: begin
                if (w_zero || w_emerg_a || w_emerg_b) w_next_state = ST_ALL_RED;
            end
            default: w_next_state = ST_ALL_RED;
        endcase
        if (w_next_state != r_state) begin
            w_load     = 1'b1;
            w_load_val = phase_len_m1(w_next_state);
        end
    end

    assign w_enter_a   = (w_next_state == ST_A_GREEN)  && (r_state != ST_A_GREEN);
    assign w_enter_b   = (w_next_state == ST_B_GREEN)  && (r_state != ST_B_GREEN);
    assign w_enter_ped = (w_next_state == ST_PED_WALK) && (r_state != ST_PED_WALK);

    // Phase register, last-grant pointer and registered lamp outputs.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state <= ST_ALL_RED;
            r_last  <= GRANT_PED;
            r_lamps <= decode_lamps(ST_ALL_RED);
        end else begin
            r_state <= w_next_state;
            r_lamps <= decode_lamps(w_next_state);
            if (w_enter_a)        r_last <= GRANT_A;
            else if (w_enter_b)   r_last <= GRANT_B;
            else if (w_enter_ped) r_last <= GRANT_PED;
        end
    end

    // Request latches: entry into the served phase beats a same-cycle request,
    // and a request for the phase already being served is ignored.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_pend_ped <= 1'b0;
        end else begin
            r_pend_a   <= w_enter_a   ? 1'b0 : (r_pend_a   | (req_a   && (r_state != ST_A_GREEN)));
            r_pend_b   <= w_enter_b   ? 1'b0 : (r_pend_b   | (req_b   && (r_state != ST_B_GREEN)));
            r_pend_ped <= w_enter_ped ? 1'b0 : (r_pend_ped | (req_ped && (r_state != ST_PED_WALK)));
        end
    end

    assign A_lights = r_lamps.a;
    assign B_lights = r_lamps.b;
    assign ped_walk = r_lamps.walk;
    assign num_out  = w_count;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: a phase/elapsed-time model
// checked every cycle, directed literal sequences, then randomized traffic.
module tb_traffic_phase_scheduler;

    localparam int GT = 8;
    localparam int YT = 3;
    localparam int RT = 2;
    localparam int WT = 6;

    localparam int P_AR = 0;
    localparam int P_AG = 1;
    localparam int P_AY = 2;
    localparam int P_BG = 3;
    localparam int P_BY = 4;
    localparam int P_PW = 5;

    logic       clk     = 1'b0;
    logic       rst_a   = 1'b0;
    logic       req_a   = 1'b0;
    logic       req_b   = 1'b0;
    logic       req_ped = 1'b0;
    logic [1:0] emerg   = 2'b00;
    logic [2:0] A_lights;
    logic [2:0] B_lights;
    logic       ped_walk;
    logic [3:0] num_out;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .ALLRED_T (RT),
        .WALK_T   (WT)
    ) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ped  (req_ped),
        .emerg    (emerg),
        .A_lights (A_lights),
        .B_lights (B_lights),
        .ped_walk (ped_walk),
        .num_out  (num_out)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase code plus cycles elapsed in it; pending[0..2] = A, B, PED; last in 0..2.
    int m_phase   = P_AR;
    int m_elapsed = 0;
    int m_last    = 2;
    bit m_pend [3] = '{1'b0, 1'b0, 1'b0};

    function automatic int dur(input int p);
        if (p == P_AR) return RT;
        if (p == P_AG || p == P_BG) return GT;
        if (p == P_AY || p == P_BY) return YT;
        return WT;
    endfunction

    function automatic int grant_phase(input int i);
        if (i == 0) return P_AG;
        if (i == 1) return P_BG;
        return P_PW;
    endfunction

    function automatic int exp_num();
        int r;
        r = dur(m_phase) - 1 - m_elapsed;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int exp_a();
        if (m_phase == P_AG) return 1;
        if (m_phase == P_AY) return 2;
        return 4;
    endfunction

    function automatic int exp_b();
        if (m_phase == P_BG) return 1;
        if (m_phase == P_BY) return 2;
        return 4;
    endfunction

    task automatic model_step();
        int nxt;
        bit expired;
        bit ea;
        bit eb;
        bit hold;
        bit req [3];
        nxt     = m_phase;
        hold    = 1'b0;
        ea      = emerg[0];
        eb      = emerg[1] && !emerg[0];
        req[0]  = req_a;
        req[1]  = req_b;
        req[2]  = req_ped;
        expired = (m_elapsed >= dur(m_phase) - 1);
        if (m_phase == P_AR) begin
            if (expired) begin
                if (ea) nxt = P_AG;
                else if (eb) nxt = P_BG;
                else begin
                    nxt = P_AG;
                    for (int k = 3; k >= 1; k--) begin
                        if (m_pend[(m_last + k) % 3]) nxt = grant_phase((m_last + k) % 3);
                    end
                end
            end
        end else if (m_phase == P_AG) begin
            if (ea) hold = 1'b1;
            else if (eb || (expired && (m_pend[1] || m_pend[2]))) nxt = P_AY;
        end else if (m_phase == P_BG) begin
            if (eb) hold = 1'b1;
            else if (ea || (expired && (m_pend[0] || m_pend[2]))) nxt = P_BY;
        end else if (m_phase == P_AY || m_phase == P_BY) begin
            if (expired) nxt = P_AR;
        end else begin
            if (expired || emerg != 2'b00) nxt = P_AR;
        end
        for (int i = 0; i < 3; i++) begin
            if (nxt == grant_phase(i) && m_phase != nxt) m_pend[i] <= 1'b0;
            else if (req[i] && m_phase != grant_phase(i)) m_pend[i] <= 1'b1;
        end
        if (nxt != m_phase) begin
            m_phase   <= nxt;
            m_elapsed <= 0;
            for (int i = 0; i < 3; i++)
                if (nxt == grant_phase(i)) m_last <= i;
        end else if (hold) begin
            m_elapsed <= 0;
        end else begin
            m_elapsed <= m_elapsed + 1;
        end
    endtask

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            m_phase   <= P_AR;
            m_elapsed <= 0;
            m_last    <= 2;
            for (int i = 0; i < 3; i++) m_pend[i] <= 1'b0;
        end else begin
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_A_lights", int'(A_lights), exp_a());
            check("model_B_lights", int'(B_lights), exp_b());
            check("model_ped_walk", int'(ped_walk), (m_phase == P_PW) ? 1 : 0);
            check("model_num_out",  int'(num_out),  exp_num());
        end
    end

    // Literal expectations that pin the model to hand-derived sequences.
    task automatic expect_out(input string tag, input logic [2:0] a, input logic [2:0] b,
                              input logic w, input int n);
        check({tag, "_A"},   int'(A_lights), int'(a));
        check({tag, "_B"},   int'(B_lights), int'(b));
        check({tag, "_walk"}, int'(ped_walk), int'(w));
        check({tag, "_num"}, int'(num_out),  n);
    endtask

    int emerg_left = 0;

    initial begin
        rst_a = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        expect_out("reset", 3'b100, 3'b100, 1'b0, 1);
        #1 rst_a = 1'b0;

        // No requests: all-red drains, then A green counts 7..0 and holds 0.
        @(negedge clk); expect_out("allred_exit", 3'b100, 3'b100, 1'b0, 0);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk); expect_out("a_green_cnt", 3'b001, 3'b100, 1'b0, i);
        end
        @(negedge clk); expect_out("a_green_hold", 3'b001, 3'b100, 1'b0, 0);

        // Single req_b pulse while A holds: yellow 2..0, all-red 1..0, B green.
        #1 req_b = 1'b1;
        @(negedge clk); expect_out("a_hold_req_b", 3'b001, 3'b100, 1'b0, 0);
        #1 req_b = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk); expect_out("a_yellow", 3'b010, 3'b100, 1'b0, i);
        end
        for (int i = 1; i >= 0; i--) begin
            @(negedge clk); expect_out("allred_to_b", 3'b100, 3'b100, 1'b0, i);
        end
        @(negedge clk); expect_out("b_green_entry", 3'b100, 3'b001, 1'b0, 7);

        // Emergency for A while B is green: B yellows at once, A held at 7.
        #1 emerg = 2'b01;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk); expect_out("b_yellow_emerg", 3'b100, 3'b010, 1'b0, i);
        end
        for (int i = 1; i >= 0; i--) begin
            @(negedge clk); expect_out("allred_emerg", 3'b100, 3'b100, 1'b0, i);
        end
        @(negedge clk); expect_out("a_emerg_entry", 3'b001, 3'b100, 1'b0, 7);
        @(negedge clk); expect_out("a_emerg_hold",  3'b001, 3'b100, 1'b0, 7);
        #1 emerg = 2'b00;
        @(negedge clk); expect_out("a_emerg_release", 3'b001, 3'b100, 1'b0, 6);

        // Asynchronous reset mid-phase is visible before the next edge.
        #1 rst_a = 1'b1;
        #1 expect_out("async_reset", 3'b100, 3'b100, 1'b0, 1);
        @(negedge clk);
        #1 rst_a = 1'b0;

        // Randomized traffic with occasional emergency bursts and resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            req_a   = ($urandom_range(0, 11) == 0);
            req_b   = ($urandom_range(0, 11) == 0);
            req_ped = ($urandom_range(0, 15) == 0);
            if (emerg_left > 0) begin
                emerg_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                emerg      = 2'($urandom_range(1, 3));
                emerg_left = $urandom_range(1, 12);
            end else begin
                emerg = 2'b00;
            end
            rst_a = ($urandom_range(0, 399) == 0);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
